hack_control_unit: RTL and testbench

Instruction-decode, register-file and program-counter stage of the HACK CPU. Sits directly upstream of the HACK ALU: drives the ALU operands and six control bits from the latched instruction and A/D registers, then consumes the ALU result and zr/ng flags to write back A, D and M and to resolve jumps. A two-state fetch/execute FSM handshakes with instruction ROM and data RAM, so memories with wait states are supported.

---
 rtl/hack_control_unit.sv | 98 +++++++++
 tb/tb_hack_control_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_control_unit.sv
// HACK CPU decode / register-file / program-counter stage.
// Two-state fetch/execute sequencer with ROM and RAM wait-state handshakes.
module hack_control_unit #(
  parameter logic [14:0] PC_RESET = 15'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic [14:0] pc,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic [15:0] in_m,
  output logic [15:0] out_m,
  output logic [14:0] address_m,
  output logic        write_m,
  input  logic        mem_ready,
  output logic        state
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;

  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [15:0] ir;
  logic [14:0] pc_reg;
  logic [0:0]  state_q;

  logic in_exec;
  logic is_c;
  logic needs_mem;
  logic commit;
  logic jump;

  assign in_exec   = (state_q == EXEC);
  assign is_c      = ir[15];
  assign needs_mem = is_c & (ir[12] | ir[3]);
  // A-instructions and register-only C-instructions never wait on RAM.
  assign commit    = in_exec & (~needs_mem | mem_ready);
  assign jump      = is_c & ((ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr));

  always_comb begin
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;
    if (is_c)
      {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[11:6];
  end

  assign alu_x     = d_reg;
  assign alu_y     = ir[12] ? in_m : a_reg;
  assign out_m     = alu_out;
  assign address_m = a_reg[14:0];
  assign write_m   = in_exec & is_c & ir[3];
  assign pc        = pc_reg;
  assign state     = state_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      d_reg   <= '0;
      ir      <= '0;
      pc_reg  <= PC_RESET;
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (instr_valid) begin
            ir      <= instr;
            state_q <= EXEC;
          end
        end
        default: begin
          if (commit) begin
            if (!is_c) begin
              a_reg <= ir;
            end else begin
              if (ir[5]) a_reg <= alu_out;
              if (ir[4]) d_reg <= alu_out;
            end
            // Jump target is the A value held before this commit.
            pc_reg  <= jump ? a_reg[14:0] : pc_reg + 15'd1;
            state_q <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_control_unit.sv
// Randomized scoreboard bench for hack_control_unit with ROM/RAM/ALU models.
module tb_hack_control_unit;

  localparam logic [14:0] TB_PC_RESET = 15'd0;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic [14:0] pc;
  logic [15:0] alu_x, alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [15:0] in_m, out_m;
  logic [14:0] address_m;
  logic        write_m;
  logic        mem_ready;
  logic        state;

  hack_control_unit #(.PC_RESET(TB_PC_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .in_m(in_m), .out_m(out_m), .address_m(address_m), .write_m(write_m),
    .mem_ready(mem_ready), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // HACK ALU behaviour: used for the external ALU and for the reference model.
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    r = c[1] ? xx + yy : xx & yy;
    if (c[0]) r = ~r;
    return r;
  endfunction

  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  logic [15:0] ram  [32768];
  logic [15:0] mram [32768];
  assign in_m = ram[address_m];
  always @(posedge clk) if (write_m && mem_ready) ram[address_m] <= out_m;

  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  typedef struct {
    logic [14:0] pc;
    logic [15:0] d;
    logic [14:0] a;
    logic        wr;
    logic [14:0] waddr;
    logic [15:0] wdata;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: an EXEC->FETCH transition marks a commit; samples of the last EXEC cycle hold the write.
  logic        prev_state = 1'b0;
  logic        prev_wm = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [15:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst_n && prev_state && !state) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_pc", 32'(pc), 32'(e.pc));
        check("commit_d", 32'(alu_x), 32'(e.d));
        check("commit_a", 32'(address_m), 32'(e.a));
        check("commit_write_m", 32'(prev_wm), 32'(e.wr));
        if (e.wr) begin
          check("commit_waddr", 32'(prev_addr), 32'(e.waddr));
          check("commit_wdata", 32'(prev_out), 32'(e.wdata));
        end
      end
    end
    prev_state = state;
    prev_wm    = write_m;
    prev_addr  = address_m;
    prev_out   = out_m;
  end

  task automatic run_instr(input logic [15:0] w, input int unsigned waits,
                           input int unsigned rom_delay);
    logic [15:0] y, r, new_a, new_d;
    logic [14:0] new_pc;
    logic        need, wr, zr, ng, jmp;
    exp_t        e;
    check("fetch_state", 32'(state), 32'd0);
    check("fetch_pc", 32'(pc), 32'(m_pc));
    for (int unsigned k = 0; k < rom_delay; k++) begin
      instr_valid = 1'b0;
      instr = 16'($urandom);
      @(posedge clk); #1;
      check("fetch_pc_hold", 32'(pc), 32'(m_pc));
    end
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    check("exec_state", 32'(state), 32'd1);

    y   = w[12] ? mram[m_a[14:0]] : m_a;
    wr  = w[15] & w[3];
    need = w[15] & (w[12] | w[3]);
    check("alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
          32'(w[15] ? w[11:6] : 6'd0));
    check("alu_x", 32'(alu_x), 32'(m_d));
    check("alu_y", 32'(alu_y), 32'(y));
    check("exec_write_m", 32'(write_m), 32'(wr));

    new_a = m_a;
    new_d = m_d;
    new_pc = m_pc + 15'd1;
    e.wr = wr;
    e.waddr = m_a[14:0];
    e.wdata = '0;
    if (!w[15]) begin
      new_a = w;
    end else begin
      r   = hack_alu(m_d, y, w[11:6]);
      zr  = (r == 16'h0000);
      ng  = r[15];
      jmp = (w[2] && ng) || (w[1] && zr) || (w[0] && !ng && !zr);
      if (jmp) new_pc = m_a[14:0];
      if (w[3]) begin
        mram[m_a[14:0]] = r;
        e.wdata = r;
      end
      if (w[5]) new_a = r;
      if (w[4]) new_d = r;
    end
    e.pc = new_pc;
    e.d  = new_d;
    e.a  = new_a[14:0];
    exp_q.push_back(e);

    if (need) begin
      for (int unsigned k = 0; k < waits; k++) begin
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("wait_state", 32'(state), 32'd1);
        check("wait_write_m", 32'(write_m), 32'(wr));
        check("wait_pc", 32'(pc), 32'(m_pc));
        check("wait_d", 32'(alu_x), 32'(m_d));
      end
    end
    mem_ready = need ? 1'b1 : 1'($urandom);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("post_commit_state", 32'(state), 32'd0);
    m_a = new_a;
    m_d = new_d;
    m_pc = new_pc;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_write_m"}, 32'(write_m), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'(TB_PC_RESET));
    check({tag, "_d"}, 32'(alu_x), 32'd0);
    check({tag, "_a"}, 32'(address_m), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i]  = 16'($urandom);
      mram[i] = ram[i];
    end
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    m_a = '0;
    m_d = '0;
    m_pc = TB_PC_RESET;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    run_instr(16'h0005, 0, 0);   // @5
    run_instr(16'hEC10, 0, 1);   // D=A
    run_instr(16'h0064, 0, 2);   // @100
    run_instr(16'hE308, 2, 0);   // M=D with two wait cycles
    run_instr(16'h002A, 0, 0);   // @42
    run_instr(16'hE301, 0, 0);   // D;JGT taken
    run_instr(16'h0005, 0, 0);
    run_instr(16'hECD0, 0, 0);   // D=-A
    run_instr(16'h002A, 0, 0);
    run_instr(16'hE301, 0, 0);   // D;JGT not taken
    run_instr(16'h0007, 0, 0);
    run_instr(16'hEAA7, 0, 0);   // A=0;JMP uses old A
    run_instr(16'h7FFF, 0, 0);
    run_instr(16'hEA87, 0, 0);   // 0;JMP to 0x7FFF
    run_instr(16'h0003, 0, 0);   // wraps to 0

    for (int n = 0; n < 200; n++) begin
      logic [15:0] w;
      if ($urandom_range(1, 0) == 0) w = {1'b0, 15'($urandom_range(63, 0))};
      else w = {1'b1, 15'($urandom)};
      run_instr(w, $urandom_range(2, 0), $urandom_range(2, 0));
    end

    // Reset during a RAM write wait.
    run_instr(16'h0064, 0, 0);
    instr = 16'hE308;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    check("abort_exec_state", 32'(state), 32'd1);
    check("abort_write_m_before", 32'(write_m), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_a = '0;
    m_d = '0;
    m_pc = TB_PC_RESET;
    run_instr(16'h0011, 0, 0);
    run_instr(16'hEC10, 0, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
